// File: rtl/sram_pio_responder.sv
// Memory-side responder for the PIO-driven SRAM port.
// One read or write per 4-phase enable pulse; done/dataout are polled by software.
module sram_pio_responder #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [ADDR_W-1:0] sram_address,
    input  logic [DATA_W-1:0] sram_datain,
    input  logic              sram_enable,
    input  logic              sram_readwrite,
    output logic [DATA_W-1:0] sram_dataout,
    output logic              sram_done,
    output logic              sram_busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        COMPLETE
    } state_t;

    state_t state, state_nx;

    logic              en_s0, en_s1, en_d;
    logic              rise;
    logic              capture;
    logic              release_done;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              rw_q;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Flops reset high so an enable held through reset never looks like a request.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            en_s0 <= 1'b1;
            en_s1 <= 1'b1;
            en_d  <= 1'b1;
        end else begin
            en_s0 <= sram_enable;
            en_s1 <= en_s0;
            en_d  <= en_s1;
        end
    end

    assign rise = en_s1 & ~en_d;

    // State register.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) state <= IDLE;
        else                state <= state_nx;
    end

    // Next-state decode; COMPLETE waits for enable low so each pulse is one access.
    always_comb begin
        state_nx     = state;
        capture      = 1'b0;
        release_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    capture  = 1'b1;
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                state_nx = COMPLETE;
            end
            COMPLETE: begin
                if (!en_s1) begin
                    release_done = 1'b1;
                    state_nx     = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Request capture and handshake outputs.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            addr_q       <= '0;
            data_q       <= '0;
            rw_q         <= 1'b0;
            sram_busy    <= 1'b0;
            sram_done    <= 1'b0;
            sram_dataout <= '0;
        end else begin
            if (capture) begin
                addr_q    <= sram_address;
                data_q    <= sram_datain;
                rw_q      <= sram_readwrite;
                sram_busy <= 1'b1;
            end
            if (state == ACCESS) begin
                sram_busy <= 1'b0;
                sram_done <= 1'b1;
                if (rw_q) sram_dataout <= mem[addr_q];
            end
            if (release_done) sram_done <= 1'b0;
        end
    end

    // Storage array; contents survive reset because state is forced out of ACCESS.
    always_ff @(posedge clk_clk) begin
        if (state == ACCESS && !rw_q) mem[addr_q] <= data_q;
    end

endmodule

// File: doc/sram_pio_responder.md
Name: sram_pio_responder

Overview:
Memory-side responder for the PIO-driven SRAM interface exported by the Nios system: software sets address, data-in, read/write and enable pins, and this block services the request.
- Contains a 2^ADDR_W x DATA_W register-array SRAM.
- Performs one read or write per enable pulse using a 4-phase req/ack handshake.
- Drives read data and a done flag back to PIO inputs, which software polls.

Parameters:
ADDR_W, 11, address width; memory depth is 2^ADDR_W words
DATA_W, 8, data word width

Ports:
clk_clk  input  1  system clock
reset_reset_n  input  1  asynchronous active-low reset
sram_address  input  ADDR_W  word address from PIO
sram_datain  input  DATA_W  write data from PIO
sram_enable  input  1  request strobe (4-phase req), asynchronous to clk_clk
sram_readwrite  input  1  1 = read, 0 = write
sram_dataout  output  DATA_W  last read data
sram_done  output  1  ack: request complete
sram_busy  output  1  request captured, access in progress

Behaviour:
- Clock and reset: one clock, clk_clk; reset_reset_n is asynchronous and active-low.
- Reset values:
  - sram_dataout = 0, sram_done = 0, sram_busy = 0, state = IDLE.
  - Enable synchronizer flops (en_s0, en_s1) and edge register en_d all reset to 1.
  - Memory contents are not reset; they are undefined after power-up and preserved across reset.
- Enable synchronization: sram_enable passes through a 2-flop synchronizer (en_s0 -> en_s1). rise = en_s1 & ~en_d, where en_d <= en_s1 every cycle.
  - Because the flops reset to 1, an enable held high through reset is never a request. Enable must be seen low before the first request.
- Address, data and readwrite are not synchronized. Software must hold them stable from before enable rises until done is seen high.
- FSM states: IDLE, ACCESS, COMPLETE.
  - IDLE: on rise, capture sram_address, sram_datain and sram_readwrite into internal regs; busy <= 1; go to ACCESS. Otherwise stay.
  - ACCESS (exactly 1 cycle):
    - Write: mem[addr_q] <= data_q.
    - Read: sram_dataout <= mem[addr_q].
    - Then busy <= 0, done <= 1, go to COMPLETE.
  - COMPLETE: hold done = 1 and sram_dataout. When en_s1 == 0: done <= 0, go to IDLE.
- Latency:
  - Enable first sampled high at edge k -> rise visible after edge k+1 -> ACCESS after edge k+2 -> done = 1 and read data valid after edge k+3.
  - Enable first sampled low at edge m -> done = 0 and IDLE after edge m+2.
- A write never changes sram_dataout. sram_dataout holds its value until the next read completes.
- Enable rising while in ACCESS or COMPLETE: no effect. COMPLETE requires enable low before IDLE, so each high pulse yields exactly one access.
- Input changes after capture (after edge k+2) have no effect on the in-flight access.
- Address range: full 0 .. 2^ADDR_W-1 with no wrap or aliasing; each address is a distinct word.
- Reset mid-operation: outputs clear immediately (asynchronously).
  - Reset during IDLE: the request is dropped.
  - Reset during ACCESS or COMPLETE: the write has either fully committed at the ACCESS edge or not occurred; no partial word.
  - After reset, enable must go low and then high again to issue a new request.

Test Plan:
- Assert reset with enable = 1, release, hold enable = 1 for 10 cycles -> done = 0, busy = 0, no access. Then drop enable and raise it with read of 0x000 -> done = 1 exactly 3 cycles after enable is sampled high.
- Write 0xA5 to 0x123, complete the handshake, then read 0x123 -> sram_dataout = 0xA5 when done rises; busy high for exactly 1 cycle.
- Write 0x3C to 0x000 and 0xC3 to 0x7FF, then read both -> 0x3C and 0xC3 respectively, with no aliasing.
- Read 0x123 (0xA5), then write 0x55 to 0x200 -> sram_dataout stays 0xA5 through the write. A later read of 0x200 returns 0x55.
- Hold enable high for 20 cycles during a write of 0x11 to 0x010, changing datain to 0xFF at cycle 5 -> single access; read of 0x010 returns 0x11. Done clears 2 cycles after enable is sampled low.
- Assert reset while in ACCESS (write 0x77 to 0x050) -> dataout, done and busy go 0 asynchronously. After re-enable, read 0x050 -> either the prior value or 0x77, never any other value.
